mcycle_unit: RTL and testbench

MCYCLE_UNIT -- requirements
Module: mcycle_unit

---
 rtl/mcycle_unit.sv | 126 ++++++++++++
 tb/tb_mcycle_unit.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mcycle_unit.sv
// Purpose: iterative unsigned multiply (shift-add) / divide (restoring), one bit per cycle.
// Latency: Start accepted in cycle 0, Busy high cycles 0..WIDTH, Done pulse in cycle WIDTH+1.
// Backpressure: Busy stalls the requester combinationally; Start is ignored unless IDLE.
module mcycle_unit #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Start,
  input  logic             MCycleOp,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  output logic [WIDTH-1:0] Result1,
  output logic [WIDTH-1:0] Result2,
  output logic             Busy,
  output logic             Done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  // acc holds {high, low}: product accumulator for multiply, {remainder, quotient/dividend} for divide
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               op_q, op_d;
  logic [WIDTH-1:0]   res1_q, res1_d;
  logic [WIDTH-1:0]   res2_q, res2_d;
  logic               done_q, done_d;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] step_next;

  // One datapath iteration for each operation; the MSB of the divide difference is the borrow.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
    div_diff = rem_sh - {1'b0, opnd_q};
    if (!div_diff[WIDTH]) begin
      div_next = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end else begin
      div_next = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end
    step_next = op_q ? div_next : mul_next;
  end

  // Next-state logic: accept in IDLE, iterate WIDTH times, publish results on the last iteration.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    op_d    = op_q;
    res1_d  = res1_q;
    res2_d  = res2_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (Start) begin
          state_d = COMPUTE;
          cnt_d   = '0;
          acc_d   = {{WIDTH{1'b0}}, Operand1};
          opnd_d  = Operand2;
          op_d    = MCycleOp;
        end
      end
      COMPUTE: begin
        acc_d = step_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
          res1_d  = step_next[WIDTH-1:0];
          res2_d  = step_next[2*WIDTH-1:WIDTH];
          done_d  = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers, cleared asynchronously so an aborted operation leaves no trace.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      op_q    <= 1'b0;
      res1_q  <= '0;
      res2_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      op_q    <= op_d;
      res1_q  <= res1_d;
      res2_q  <= res2_d;
      done_q  <= done_d;
    end
  end

  // Busy must stall the pipeline in the same cycle Start is raised, so it is not registered.
  assign Busy    = ~Reset & ((state_q == COMPUTE) | ((state_q == IDLE) & Start));
  assign Done    = done_q;
  assign Result1 = res1_q;
  assign Result2 = res2_q;

endmodule

// File: tb/tb_mcycle_unit.sv
// Directed bench for mcycle_unit with WIDTH=32: table of operations plus reset-abort and held-Start sequences.
module tb_mcycle_unit;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        Start;
  logic        MCycleOp;
  logic [31:0] Operand1;
  logic [31:0] Operand2;
  logic [31:0] Result1;
  logic [31:0] Result2;
  logic        Busy;
  logic        Done;

  int checks = 0;
  int errors = 0;

  logic [31:0] prev_r1 = '0;
  logic [31:0] prev_r2 = '0;

  typedef struct {
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r1;
    logic [31:0] r2;
    int          glitch;
  } vec_t;

  vec_t tv[10];

  mcycle_unit #(.WIDTH(32)) dut (
    .CLK      (CLK),
    .Reset    (Reset),
    .Start    (Start),
    .MCycleOp (MCycleOp),
    .Operand1 (Operand1),
    .Operand2 (Operand2),
    .Result1  (Result1),
    .Result2  (Result2),
    .Busy     (Busy),
    .Done     (Done)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at posedge+1 in IDLE. Presents an operation in cycle 0, then scrambles operands
  // every cycle; optionally pulses Start with other operands in cycle glitch_cyc.
  task automatic do_op(input logic op, input logic [31:0] a, input logic [31:0] b,
                       input int glitch_cyc, output int busy_n, output int done_c);
    busy_n   = 0;
    done_c   = -1;
    Start    = 1'b1;
    MCycleOp = op;
    Operand1 = a;
    Operand2 = b;
    for (int c = 0; c < 40 && done_c < 0; c++) begin
      @(negedge CLK);
      if (Busy) busy_n++;
      if (Done) done_c = c;
      if (c == 20) begin
        check("hold_r1", {32'd0, Result1}, {32'd0, prev_r1});
        check("hold_r2", {32'd0, Result2}, {32'd0, prev_r2});
      end
      @(posedge CLK);
      #1;
      Operand1 = $urandom;
      Operand2 = $urandom;
      MCycleOp = ~op;
      Start    = (c + 1 == glitch_cyc);
    end
    Start = 1'b0;
  endtask

  initial begin
    int busy_n, done_c, seen, bad, last_done, ndone;

    tv[0] = '{1'b0, 32'd7,          32'd6,          32'd42,         32'd0,          -1};
    tv[1] = '{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000001,   32'hFFFFFFFE,   -1};
    tv[2] = '{1'b1, 32'd100,        32'd7,          32'd14,         32'd2,          -1};
    tv[3] = '{1'b1, 32'd5,          32'd0,          32'hFFFFFFFF,   32'd5,          -1};
    tv[4] = '{1'b0, 32'h12345678,   32'h00000010,   32'h23456780,   32'h00000001,   -1};
    tv[5] = '{1'b1, 32'hFFFFFFFF,   32'h00000010,   32'h0FFFFFFF,   32'h0000000F,   -1};
    tv[6] = '{1'b0, 32'd0,          32'd5,          32'd0,          32'd0,          -1};
    tv[7] = '{1'b1, 32'd7,          32'd100,        32'd0,          32'd7,          -1};
    tv[8] = '{1'b0, 32'h80000000,   32'd2,          32'd0,          32'd1,          -1};
    tv[9] = '{1'b0, 32'd3,          32'd5,          32'd15,         32'd0,          10};

    // Reset state, with Start high to show Busy is masked by Reset.
    Reset    = 1'b1;
    Start    = 1'b1;
    MCycleOp = 1'b0;
    Operand1 = 32'd1;
    Operand2 = 32'd1;
    #2;
    check("rst_busy", {63'd0, Busy}, 64'd0);
    check("rst_done", {63'd0, Done}, 64'd0);
    check("rst_r1", {32'd0, Result1}, 64'd0);
    check("rst_r2", {32'd0, Result2}, 64'd0);
    @(posedge CLK);
    #1;
    Start = 1'b0;
    Reset = 1'b0;
    #1;
    check("idle_busy", {63'd0, Busy}, 64'd0);
    Start = 1'b1;
    #1;
    check("comb_busy", {63'd0, Busy}, 64'd1);
    Start = 1'b0;
    @(posedge CLK);
    #1;

    for (int i = 0; i < 10; i++) begin
      do_op(tv[i].op, tv[i].a, tv[i].b, tv[i].glitch, busy_n, done_c);
      check($sformatf("v%0d_busy_cycles", i), 64'(busy_n), 64'd33);
      check($sformatf("v%0d_done_cycle", i), 64'(done_c), 64'd33);
      check($sformatf("v%0d_r1", i), {32'd0, Result1}, {32'd0, tv[i].r1});
      check($sformatf("v%0d_r2", i), {32'd0, Result2}, {32'd0, tv[i].r2});
      prev_r1 = tv[i].r1;
      prev_r2 = tv[i].r2;
    end

    // Reset pulsed in cycle 15 of a divide: immediate clear, no Done afterwards.
    Start    = 1'b1;
    MCycleOp = 1'b1;
    Operand1 = 32'd100;
    Operand2 = 32'd7;
    @(posedge CLK);
    #1;
    Start = 1'b0;
    repeat (14) @(posedge CLK);
    #2;
    Reset = 1'b1;
    #1;
    check("abort_busy", {63'd0, Busy}, 64'd0);
    check("abort_r1", {32'd0, Result1}, 64'd0);
    check("abort_r2", {32'd0, Result2}, 64'd0);
    @(posedge CLK);
    #1;
    Reset = 1'b0;
    seen  = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge CLK);
      if (Done) seen++;
    end
    check("abort_no_done", 64'(seen), 64'd0);
    @(posedge CLK);
    #1;
    prev_r1 = '0;
    prev_r2 = '0;
    do_op(1'b0, 32'd3, 32'd3, -1, busy_n, done_c);
    check("post_rst_done_cycle", 64'(done_c), 64'd33);
    check("post_rst_r1", {32'd0, Result1}, 64'd9);
    check("post_rst_r2", {32'd0, Result2}, 64'd0);

    // Start held high: back-to-back operations, Done every 34 cycles, Busy low only on Done.
    Start     = 1'b1;
    MCycleOp  = 1'b0;
    Operand1  = 32'd2;
    Operand2  = 32'd3;
    bad       = 0;
    ndone     = 0;
    last_done = -1;
    for (int c = 0; c < 110 && ndone < 3; c++) begin
      @(negedge CLK);
      if (Busy == Done) bad++;
      if (Done) begin
        if (ndone == 0) check("held_first_done", 64'(c), 64'd33);
        else            check("held_period", 64'(c - last_done), 64'd34);
        last_done = c;
        ndone++;
      end
      @(posedge CLK);
      #1;
      if (ndone == 3) Start = 1'b0;
    end
    Start = 1'b0;
    check("held_done_count", 64'(ndone), 64'd3);
    check("held_busy_pattern", 64'(bad), 64'd0);
    check("held_r1", {32'd0, Result1}, 64'd6);
    @(negedge CLK);
    check("held_stop_busy", {63'd0, Busy}, 64'd0);
    repeat (2) @(negedge CLK);
    check("held_stop_idle", {63'd0, Busy}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
